param_code_lock: RTL
====================

# param_code_lock

Parametrised keypad code lock, the next generation of the team's 4-digit electronic lock. It collects a CODE_LEN-digit entry from a strobed keypad and compares it against a stored code. It adds a fail counter with a timed lockout, a configurable unlock hold time, and passcode reprogramming with confirmation. It sits between the keypad decoder and the latch driver at the top level.

## Interface
- CODE_LEN, 4: digits per code (≥1)
- DIGIT_W, 4: key code width
- KEY_SET, 4'hE: key code requesting reprogramming
- KEY_CANCEL, 4'hD: key code aborting the current operation
- RESET_CODE, 16'h1234: code loaded at reset, CODE_LEN*DIGIT_W bits, first digit in MSBs
- UNLOCK_CYCLES, 5: cycles unlocked stays high (≥1)
- MAX_FAILS, 3: consecutive failed entries that trigger lockout (≥1)
- LOCKOUT_CYCLES, 1000: lockout duration in cycles (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- key_in  in  DIGIT_W  key code; a digit is any value other than KEY_SET or KEY_CANCEL
- key_valid  in  1  one-cycle strobe; key_in is sampled only when high
- unlocked  out  1  latch release
- locked_out  out  1  lockout active, all keys ignored
- prog_active  out  1  in PROG or CONFIRM
- err  out  1  one-cycle pulse: wrong code or confirm mismatch
- prog_ok  out  1  one-cycle pulse: new code committed
- fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive failure count

## Operation
- States: IDLE, ENTRY, OPEN, PROG, CONFIRM, LOCKOUT. Registers: stored code, shadow code, digit index, mismatch flag, down-timer sized for max(UNLOCK_CYCLES, LOCKOUT_CYCLES).
- IDLE: a digit compares against stored digit 0, sets the mismatch flag if unequal, and moves to ENTRY with index 1. KEY_SET and KEY_CANCEL are ignored.
- ENTRY: each digit compares against stored digit[index], ORs into the mismatch flag, and increments the index. The verdict comes only after digit CODE_LEN. There is no early reject, so the position of the first wrong digit is never revealed. KEY_SET is ignored. KEY_CANCEL returns to IDLE and does not count as a failure.
- Verdict on a match: go to OPEN, load the timer with UNLOCK_CYCLES, clear fail_cnt.
- Verdict on a mismatch: pulse err and increment fail_cnt. If fail_cnt reaches MAX_FAILS, go to LOCKOUT with the timer loaded with LOCKOUT_CYCLES. Otherwise go to IDLE.
- OPEN: unlocked=1 and the timer decrements each cycle. At expiry, go to IDLE. KEY_CANCEL relocks immediately and goes to IDLE. KEY_SET goes to PROG, and unlocked drops the next cycle. Digits are ignored.
- PROG: CODE_LEN digits fill the shadow register, then go to CONFIRM. KEY_SET is ignored.
- CONFIRM: CODE_LEN digits compare against the shadow register.
  - All equal: stored code is set to shadow, pulse prog_ok, go to IDLE.
  - Otherwise: pulse err, discard shadow, go to IDLE. fail_cnt is unchanged.
  - KEY_CANCEL in PROG or CONFIRM discards shadow, goes to IDLE, and leaves the stored code untouched.
- LOCKOUT: all keys are dropped, including KEY_CANCEL. At timer expiry, clear fail_cnt and go to IDLE.
- Reset: state IDLE, stored code set to RESET_CODE, shadow/index/mismatch/timer/fail_cnt set to 0, every output 0. Reset mid-operation aborts anything in progress, including a half-entered new code. The stored code reverts to RESET_CODE.

## Timing
- All outputs are registered. A key accepted at edge t takes effect from cycle t+1.
- Final correct digit at edge t: unlocked is high for cycles t+1 through t+UNLOCK_CYCLES inclusive, then low.
- Final wrong digit at edge t: err is high in cycle t+1 only, and fail_cnt updates in t+1. On the MAX_FAILS-th failure, locked_out is high for exactly LOCKOUT_CYCLES cycles starting at t+1.
- prog_ok and err are exactly one cycle wide.
- If key_valid coincides with the last OPEN cycle or the last LOCKOUT cycle, the expiry wins and the key is dropped.
- key_valid may be asserted on consecutive cycles; every strobe counts. Keys arriving while key_valid is low are invisible.
- When CODE_LEN=1, ENTRY is skipped: the IDLE digit produces the verdict directly.

## Test plan
- Reset, then keys 1,2,3,4 (default code) -> unlocked high exactly 5 cycles, starting the cycle after the 4th strobe; fail_cnt=0.
- Keys 1,9,3,4 -> no reaction until the 4th key, then an err pulse and fail_cnt=1. Three such entries -> locked_out high 1000 cycles; keys 1,2,3,4 during lockout -> no unlock; after lockout, fail_cnt=0 and 1,2,3,4 unlocks.
- Unlock, KEY_SET, 5,6,7,8, then 5,6,7,8 -> prog_ok pulse. Then 1,2,3,4 -> err; 5,6,7,8 -> unlocked.
- Unlock, KEY_SET, 5,6,7,8, then 5,6,7,9 -> err; stored code remains 1,2,3,4.
- Keys 1,2 then KEY_CANCEL, then 1,2,3,4 -> unlocked, fail_cnt stays 0. KEY_CANCEL during OPEN -> unlocked low the next cycle.
- rst_n low during CONFIRM after a committed code change -> all outputs 0 and the code reverts to 1,2,3,4. Also run CODE_LEN=6, UNLOCK_CYCLES=2, MAX_FAILS=1 with the same sequences scaled to the new parameters.

Source files
------------

// File: rtl/param_code_lock.sv
// Parametrised keypad code lock: digit entry against a stored code, fail counter
// with timed lockout, timed unlock window and two-pass passcode reprogramming.
module param_code_lock #(
   parameter int                            CODE_LEN       = 4,
   parameter int                            DIGIT_W        = 4,
   parameter logic [DIGIT_W-1:0]            KEY_SET        = DIGIT_W'('hE),
   parameter logic [DIGIT_W-1:0]            KEY_CANCEL     = DIGIT_W'('hD),
   parameter logic [CODE_LEN*DIGIT_W-1:0]   RESET_CODE     = (CODE_LEN*DIGIT_W)'('h1234),
   parameter int                            UNLOCK_CYCLES  = 5,
   parameter int                            MAX_FAILS      = 3,
   parameter int                            LOCKOUT_CYCLES = 1000
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [DIGIT_W-1:0]                 key_in,
   input  logic                               key_valid,
   output logic                               unlocked,
   output logic                               locked_out,
   output logic                               prog_active,
   output logic                               err,
   output logic                               prog_ok,
   output logic [$clog2(MAX_FAILS+1)-1:0]     fail_cnt
);

   localparam int CODE_W  = CODE_LEN * DIGIT_W;
   localparam int IDX_W   = $clog2(CODE_LEN + 1);
   localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int FAIL_W  = $clog2(MAX_FAILS + 1);

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(CODE_LEN - 1);
   localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAILS - 1);
   localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
   localparam logic [TMR_W-1:0]  TMR_OPEN  = TMR_W'(UNLOCK_CYCLES);
   localparam logic [TMR_W-1:0]  TMR_LOCK  = TMR_W'(LOCKOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE, S_ENTRY, S_OPEN, S_PROG, S_CONFIRM, S_LOCKOUT
   } state_e;

   state_e              state_q;
   logic [CODE_W-1:0]   code_q;
   logic [CODE_W-1:0]   shadow_q;
   logic [IDX_W-1:0]    idx_q;
   logic                mism_q;
   logic [TMR_W-1:0]    timer_q;
   logic [FAIL_W-1:0]   fail_q;
   logic                unlocked_q;
   logic                locked_out_q;
   logic                prog_active_q;
   logic                err_q;
   logic                prog_ok_q;

   logic                is_set;
   logic                is_cancel;
   logic                is_digit;
   logic                last_dig;
   logic [DIGIT_W-1:0]  ref_dig;
   logic                mism_d;

   // idx_q and mism_q are zero whenever IDLE, PROG or CONFIRM is entered, so
   // the running compare can use them directly in every collecting state.
   always_comb begin
      is_set    = (key_in == KEY_SET);
      is_cancel = (key_in == KEY_CANCEL);
      is_digit  = !is_set && !is_cancel;
      last_dig  = (idx_q == LAST_IDX);
      ref_dig   = code_q[(CODE_LEN - 1 - int'(idx_q)) * DIGIT_W +: DIGIT_W];
      if (state_q == S_CONFIRM) begin
         ref_dig = shadow_q[(CODE_LEN - 1 - int'(idx_q)) * DIGIT_W +: DIGIT_W];
      end
      mism_d = mism_q | (key_in != ref_dig);
   end

   always_ff @(posedge clk) begin
      // NOTE: the stored code is an ordinary register and is reset like the
      // rest; a reset mid-reprogramming must restore RESET_CODE.
      if (!rst_n) begin
         state_q       <= S_IDLE;
         code_q        <= RESET_CODE;
         shadow_q      <= '0;
         idx_q         <= '0;
         mism_q        <= 1'b0;
         timer_q       <= '0;
         fail_q        <= '0;
         unlocked_q    <= 1'b0;
         locked_out_q  <= 1'b0;
         prog_active_q <= 1'b0;
         err_q         <= 1'b0;
         prog_ok_q     <= 1'b0;
      end else begin
         err_q     <= 1'b0;
         prog_ok_q <= 1'b0;
         unique case (state_q)
            S_IDLE, S_ENTRY: begin
               if (key_valid && is_cancel && state_q == S_ENTRY) begin
                  state_q <= S_IDLE;
                  idx_q   <= '0;
                  mism_q  <= 1'b0;
               end else if (key_valid && is_digit) begin
                  if (last_dig) begin
                     idx_q  <= '0;
                     mism_q <= 1'b0;
                     if (!mism_d) begin
                        state_q    <= S_OPEN;
                        timer_q    <= TMR_OPEN;
                        unlocked_q <= 1'b1;
                        fail_q     <= '0;
                     end else begin
                        err_q  <= 1'b1;
                        fail_q <= fail_q + 1'b1;
                        if (fail_q == FAIL_LAST) begin
                           state_q      <= S_LOCKOUT;
                           timer_q      <= TMR_LOCK;
                           locked_out_q <= 1'b1;
                        end else begin
                           state_q <= S_IDLE;
                        end
                     end
                  end else begin
                     state_q <= S_ENTRY;
                     idx_q   <= idx_q + 1'b1;
                     mism_q  <= mism_d;
                  end
               end
            end

            // Expiry is checked first so a key on the final open cycle is dropped.
            S_OPEN: begin
               if (timer_q == TMR_ONE) begin
                  state_q    <= S_IDLE;
                  timer_q    <= '0;
                  unlocked_q <= 1'b0;
               end else if (key_valid && is_cancel) begin
                  state_q    <= S_IDLE;
                  timer_q    <= '0;
                  unlocked_q <= 1'b0;
               end else if (key_valid && is_set) begin
                  state_q       <= S_PROG;
                  timer_q       <= '0;
                  unlocked_q    <= 1'b0;
                  prog_active_q <= 1'b1;
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end

            S_PROG, S_CONFIRM: begin
               if (key_valid && is_cancel) begin
                  state_q       <= S_IDLE;
                  shadow_q      <= '0;
                  idx_q         <= '0;
                  mism_q        <= 1'b0;
                  prog_active_q <= 1'b0;
               end else if (key_valid && is_digit && state_q == S_PROG) begin
                  shadow_q[(CODE_LEN - 1 - int'(idx_q)) * DIGIT_W +: DIGIT_W] <= key_in;
                  if (last_dig) begin
                     state_q <= S_CONFIRM;
                     idx_q   <= '0;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end else if (key_valid && is_digit) begin
                  if (last_dig) begin
                     if (!mism_d) begin
                        code_q    <= shadow_q;
                        prog_ok_q <= 1'b1;
                     end else begin
                        err_q <= 1'b1;
                     end
                     state_q       <= S_IDLE;
                     shadow_q      <= '0;
                     idx_q         <= '0;
                     mism_q        <= 1'b0;
                     prog_active_q <= 1'b0;
                  end else begin
                     idx_q  <= idx_q + 1'b1;
                     mism_q <= mism_d;
                  end
               end
            end

            S_LOCKOUT: begin
               if (timer_q == TMR_ONE) begin
                  state_q      <= S_IDLE;
                  timer_q      <= '0;
                  fail_q       <= '0;
                  locked_out_q <= 1'b0;
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign unlocked    = unlocked_q;
   assign locked_out  = locked_out_q;
   assign prog_active = prog_active_q;
   assign err         = err_q;
   assign prog_ok     = prog_ok_q;
   assign fail_cnt    = fail_q;

endmodule
